// File: rtl/trace_checker.sv
// trace_checker: lock-step comparison of a CPU's write-back commit stream
// against a golden trace. Commits are buffered in a small FIFO so the golden
// source can lag the core. The checker ends in PASS on the last golden entry,
// or in FAIL on a mismatch, a FIFO overflow or a commit-starvation timeout.
module trace_checker #(
    parameter int FIFO_DEPTH  = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wb_have_inst,
    input  logic [31:0] wb_pc,
    input  logic        wb_ena,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_value,
    input  logic        g_valid,
    output logic        g_ready,
    input  logic [31:0] g_pc,
    input  logic        g_ena,
    input  logic [4:0]  g_reg,
    input  logic [31:0] g_value,
    input  logic        g_last,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  fail_cause,
    output logic [31:0] err_pc,
    output logic [31:0] err_exp_value,
    output logic [31:0] err_got_value,
    output logic [31:0] commit_cnt
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH      = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0] CNT_ONE    = 1;
    localparam logic [31:0] WDOG_LIMIT = WDOG_CYCLES - 1;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISMATCH = 2'b01;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

    // One buffered commit; ena is stored already normalised (x0 never writes)
    typedef struct packed {
        logic [31:0] pc;
        logic        ena;
        logic [4:0]  rd;
        logic [31:0] value;
    } entry_t;

    state_t        state_reg;
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [31:0]   wdog_reg;

    logic   running;
    logic   push;
    logic   pop;
    logic   full;
    logic   wr_en;
    logic   g_ena_n;
    logic   fields_match;
    logic   hit;
    logic   mismatch;
    logic   overflow;
    logic   timeout;
    entry_t incoming;
    entry_t head;

    // Per-cycle handshake, compare and failure decode
    always_comb begin
        running      = (state_reg == ST_RUN);
        g_ready      = running && (count_reg != '0);
        push         = running && wb_have_inst;
        pop          = g_valid && g_ready;
        full         = (count_reg == DEPTH);
        // A push into a full FIFO is only accepted when the head leaves in the same cycle
        wr_en        = push && (!full || pop);
        incoming     = {wb_pc, wb_ena && (wb_reg != 5'd0), wb_reg, wb_value};
        head         = mem[rd_ptr_reg];
        g_ena_n      = g_ena && (g_reg != 5'd0);
        fields_match = (head.pc == g_pc) && (head.ena == g_ena_n) &&
                       (!head.ena || ((head.rd == g_reg) && (head.value == g_value)));
        hit          = pop && fields_match;
        mismatch     = pop && !fields_match;
        overflow     = push && full && !pop;
        timeout      = running && !push && (wdog_reg == WDOG_LIMIT);
    end

    // FIFO storage; no reset needed because occupancy gates every read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= incoming;
        end
    end

    // Checker FSM with FIFO bookkeeping, watchdog and failure capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            busy          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            fail_cause    <= CAUSE_NONE;
            err_pc        <= '0;
            err_exp_value <= '0;
            err_got_value <= '0;
            commit_cnt    <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            wdog_reg      <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (wr_en) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                    end
                    if (wr_en && !pop) begin
                        count_reg <= count_reg + CNT_ONE;
                    end else if (!wr_en && pop) begin
                        count_reg <= count_reg - CNT_ONE;
                    end
                    // The watchdog tracks commits from the core, not golden progress
                    wdog_reg <= push ? '0 : wdog_reg + 32'd1;
                    if (hit) begin
                        commit_cnt <= commit_cnt + 32'd1;
                    end
                    // Outcome priority: mismatch, then overflow, then timeout, then pass
                    if (mismatch) begin
                        state_reg     <= ST_FAIL;
                        busy          <= 1'b0;
                        fail          <= 1'b1;
                        fail_cause    <= CAUSE_MISMATCH;
                        err_pc        <= head.pc;
                        err_exp_value <= g_value;
                        err_got_value <= head.value;
                    end else if (overflow) begin
                        state_reg  <= ST_FAIL;
                        busy       <= 1'b0;
                        fail       <= 1'b1;
                        fail_cause <= CAUSE_OVERFLOW;
                        err_pc     <= wb_pc;
                    end else if (timeout) begin
                        state_reg  <= ST_FAIL;
                        busy       <= 1'b0;
                        fail       <= 1'b1;
                        fail_cause <= CAUSE_TIMEOUT;
                        err_pc     <= '0;
                    end else if (hit && g_last) begin
                        state_reg <= ST_PASS;
                        busy      <= 1'b0;
                        pass      <= 1'b1;
                    end
                end
                default: begin
                    // IDLE, PASS and FAIL all wait for start; results stay sticky until then
                    if (start) begin
                        state_reg     <= ST_RUN;
                        busy          <= 1'b1;
                        pass          <= 1'b0;
                        fail          <= 1'b0;
                        fail_cause    <= CAUSE_NONE;
                        err_pc        <= '0;
                        err_exp_value <= '0;
                        err_got_value <= '0;
                        commit_cnt    <= '0;
                        wr_ptr_reg    <= '0;
                        rd_ptr_reg    <= '0;
                        count_reg     <= '0;
                        wdog_reg      <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// tb_trace_checker: table vectors for the match rule, hand sequences for the
// multi-cycle corners, and a randomized run against a queue-based model.
module tb_trace_checker;

    localparam int DEPTH = 4;
    localparam int WDOG  = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        wb_have_inst;
    logic [31:0] wb_pc;
    logic        wb_ena;
    logic [4:0]  wb_reg;
    logic [31:0] wb_value;
    logic        g_valid;
    logic        g_ready;
    logic [31:0] g_pc;
    logic        g_ena;
    logic [4:0]  g_reg;
    logic [31:0] g_value;
    logic        g_last;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_cause;
    logic [31:0] err_pc;
    logic [31:0] err_exp_value;
    logic [31:0] err_got_value;
    logic [31:0] commit_cnt;

    trace_checker #(.FIFO_DEPTH(DEPTH), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .start(start),
        .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .wb_ena(wb_ena),
        .wb_reg(wb_reg), .wb_value(wb_value),
        .g_valid(g_valid), .g_ready(g_ready), .g_pc(g_pc), .g_ena(g_ena),
        .g_reg(g_reg), .g_value(g_value), .g_last(g_last),
        .busy(busy), .pass(pass), .fail(fail), .fail_cause(fail_cause),
        .err_pc(err_pc), .err_exp_value(err_exp_value),
        .err_got_value(err_got_value), .commit_cnt(commit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk_w(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        start = 1'b0; wb_have_inst = 1'b0; wb_pc = '0; wb_ena = 1'b0; wb_reg = '0; wb_value = '0;
        g_valid = 1'b0; g_pc = '0; g_ena = 1'b0; g_reg = '0; g_value = '0; g_last = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_wb(input logic [31:0] pc, input logic ena, input logic [4:0] rg, input logic [31:0] val);
        wb_have_inst = 1'b1; wb_pc = pc; wb_ena = ena; wb_reg = rg; wb_value = val;
    endtask

    task automatic set_g(input logic [31:0] pc, input logic ena, input logic [4:0] rg, input logic [31:0] val, input logic last);
        g_valid = 1'b1; g_pc = pc; g_ena = ena; g_reg = rg; g_value = val; g_last = last;
    endtask

    task automatic chk_reset_state(input string tag);
        chk_b({tag, ".busy"}, busy, 1'b0);
        chk_b({tag, ".pass"}, pass, 1'b0);
        chk_b({tag, ".fail"}, fail, 1'b0);
        chk_b({tag, ".g_ready"}, g_ready, 1'b0);
        chk_w({tag, ".cause"}, {30'd0, fail_cause}, 32'd0);
        chk_w({tag, ".cnt"}, commit_cnt, 32'd0);
        chk_w({tag, ".err_pc"}, err_pc, 32'd0);
        chk_w({tag, ".err_exp"}, err_exp_value, 32'd0);
        chk_w({tag, ".err_got"}, err_got_value, 32'd0);
    endtask

    // ---------------- table vectors: single commit vs single golden entry ----------------
    typedef struct {
        logic [31:0] d_pc; logic d_ena; logic [4:0] d_rg; logic [31:0] d_val;
        logic [31:0] g_pc; logic g_ena; logic [4:0] g_rg; logic [31:0] g_val;
        logic        exp_pass;
        logic [1:0]  exp_cause;
        logic [31:0] exp_epc, exp_eexp, exp_egot, exp_cnt;
    } vec_t;

    // A mismatching row captures the head pc, the golden value and the DUT value
    function automatic vec_t mkv(input logic [31:0] dpc, input logic de, input logic [4:0] dr, input logic [31:0] dv,
                                 input logic [31:0] gpc, input logic ge, input logic [4:0] gr, input logic [31:0] gv,
                                 input logic ok);
        vec_t v;
        v.d_pc = dpc; v.d_ena = de; v.d_rg = dr; v.d_val = dv;
        v.g_pc = gpc; v.g_ena = ge; v.g_rg = gr; v.g_val = gv;
        v.exp_pass  = ok;
        v.exp_cause = ok ? 2'b00 : 2'b01;
        v.exp_epc   = ok ? 32'd0 : dpc;
        v.exp_eexp  = ok ? 32'd0 : gv;
        v.exp_egot  = ok ? 32'd0 : dv;
        v.exp_cnt   = ok ? 32'd1 : 32'd0;
        return v;
    endfunction

    // ---------------- reference model for the randomized run ----------------
    typedef struct { logic [31:0] pc; logic ena; logic [4:0] rg; logic [31:0] value; } ent_t;
    typedef struct { ent_t d; ent_t g; } pair_t;

    pair_t       mq[$];
    bit          m_run, m_pass, m_fail;
    logic [1:0]  m_cause;
    logic [31:0] m_cnt, m_epc, m_eexp, m_egot;
    int          m_idle;
    int          episode;

    function automatic bit ent_match(input ent_t d, input ent_t g);
        bit de, ge;
        de = d.ena && (d.rg != 0);
        ge = g.ena && (g.rg != 0);
        if (d.pc != g.pc || de != ge) return 1'b0;
        if (!de) return 1'b1;
        return (d.rg == g.rg) && (d.value == g.value);
    endfunction

    task automatic model_reset;
        mq.delete();
        m_run = 0; m_pass = 0; m_fail = 0; m_cause = 0;
        m_cnt = 0; m_epc = 0; m_eexp = 0; m_egot = 0; m_idle = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently driven
    task automatic model_edge(input ent_t d, input ent_t g_new, input ent_t g_cur);
        bit hs, ok, ovf, tmo;
        if (!m_run) begin
            if (start) begin
                model_reset();
                m_run = 1;
            end
            return;
        end
        hs  = g_valid && (mq.size() != 0);
        ok  = hs && ent_match(mq[0].d, g_cur);
        ovf = wb_have_inst && (mq.size() == DEPTH) && !hs;
        tmo = !wb_have_inst && (m_idle == WDOG - 1);
        if (ok) m_cnt++;
        if (hs && !ok) begin
            m_fail = 1; m_cause = 2'b01; m_epc = mq[0].d.pc; m_eexp = g_cur.value; m_egot = mq[0].d.value;
        end else if (ovf) begin
            m_fail = 1; m_cause = 2'b10; m_epc = d.pc;
        end else if (tmo) begin
            m_fail = 1; m_cause = 2'b11; m_epc = 0;
        end else if (ok && g_last) begin
            m_pass = 1;
        end
        if (hs) void'(mq.pop_front());
        if (wb_have_inst && !ovf) mq.push_back('{d: d, g: g_new});
        m_idle = wb_have_inst ? 0 : m_idle + 1;
        if (m_pass || m_fail) begin
            m_run = 0;
            mq.delete();
            $display("rand episode %0d: end pass=%0b cause=%0d commits=%0d", episode, m_pass, m_cause, m_cnt);
        end
    endtask

    function automatic ent_t make_gold(input ent_t d);
        ent_t g;
        g = d;
        if (!(d.ena && d.rg != 0)) begin
            // Any non-writing form is equivalent: value/reg are don't-care
            g.value = $urandom;
            g.rg    = 5'($urandom_range(0, 31));
            g.ena   = (g.rg == 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
        if ($urandom_range(0, 29) == 0) begin
            if (g.ena && g.rg != 0) g.value = g.value ^ (32'd1 << $urandom_range(0, 31));
            else                    g.pc    = g.pc ^ 32'd4;
        end
        return g;
    endfunction

    initial begin
        vec_t vecs[9];
        ent_t d, gn, gc;
        int   p_commit, p_gvalid;

        vecs[0] = mkv(32'h20, 1'b1, 5'd5,  32'hDEAD,  32'h20, 1'b1, 5'd5,  32'hDEAD, 1'b1);
        vecs[1] = mkv(32'h10, 1'b1, 5'd3,  32'h6,     32'h10, 1'b1, 5'd3,  32'h5,    1'b0);
        vecs[2] = mkv(32'h30, 1'b1, 5'd4,  32'h7,     32'h30, 1'b1, 5'd6,  32'h7,    1'b0);
        vecs[3] = mkv(32'h40, 1'b1, 5'd2,  32'h9,     32'h44, 1'b1, 5'd2,  32'h9,    1'b0);
        vecs[4] = mkv(32'h50, 1'b1, 5'd7,  32'h1,     32'h50, 1'b0, 5'd7,  32'h1,    1'b0);
        vecs[5] = mkv(32'h60, 1'b0, 5'd8,  32'h11,    32'h60, 1'b0, 5'd9,  32'h22,   1'b1);
        vecs[6] = mkv(32'h70, 1'b1, 5'd0,  32'h1234,  32'h70, 1'b0, 5'd0,  32'h0,    1'b1);
        vecs[7] = mkv(32'h80, 1'b0, 5'd3,  32'h5,     32'h80, 1'b1, 5'd0,  32'h99,   1'b1);
        vecs[8] = mkv(32'h90, 1'b1, 5'd0,  32'h5,     32'h90, 1'b1, 5'd12, 32'h5,    1'b0);

        clear_inputs();
        rst = 1'b1;
        #1;
        chk_reset_state("reset");
        $display("reset: outputs at reset values");
        @(posedge clk);
        #3;
        rst = 1'b0;

        // ---- three matching commits, last one ends the trace ----
        do_start();
        chk_b("seq3.busy", busy, 1'b1);
        set_wb(32'h0, 1'b1, 5'd1, 32'hA);
        set_g(32'h0, 1'b1, 5'd1, 32'hA, 1'b0);
        chk_b("seq3.ready_empty", g_ready, 1'b0);
        tick();
        set_wb(32'h4, 1'b1, 5'd2, 32'hB);
        chk_b("seq3.ready_one", g_ready, 1'b1);
        tick();
        set_wb(32'h8, 1'b1, 5'd3, 32'hC);
        set_g(32'h4, 1'b1, 5'd2, 32'hB, 1'b0);
        tick();
        wb_have_inst = 1'b0;
        set_g(32'h8, 1'b1, 5'd3, 32'hC, 1'b1);
        chk_b("seq3.pass_early", pass, 1'b0);
        chk_w("seq3.cnt_mid", commit_cnt, 32'd2);
        tick();
        clear_inputs();
        chk_b("seq3.pass", pass, 1'b1);
        chk_b("seq3.busy_end", busy, 1'b0);
        chk_b("seq3.fail", fail, 1'b0);
        chk_w("seq3.cnt", commit_cnt, 32'd3);
        chk_w("seq3.cause", {30'd0, fail_cause}, 32'd0);
        $display("seq3: three commits compared, pass=%0b cnt=%0d", pass, commit_cnt);

        // ---- match-rule table ----
        for (int i = 0; i < 9; i++) begin
            do_start();
            set_wb(vecs[i].d_pc, vecs[i].d_ena, vecs[i].d_rg, vecs[i].d_val);
            tick();
            wb_have_inst = 1'b0;
            set_g(vecs[i].g_pc, vecs[i].g_ena, vecs[i].g_rg, vecs[i].g_val, 1'b1);
            chk_b($sformatf("vec%0d.ready", i), g_ready, 1'b1);
            tick();
            clear_inputs();
            chk_b($sformatf("vec%0d.pass", i), pass, vecs[i].exp_pass);
            chk_b($sformatf("vec%0d.fail", i), fail, !vecs[i].exp_pass);
            chk_w($sformatf("vec%0d.cause", i), {30'd0, fail_cause}, {30'd0, vecs[i].exp_cause});
            chk_w($sformatf("vec%0d.cnt", i), commit_cnt, vecs[i].exp_cnt);
            chk_w($sformatf("vec%0d.err_pc", i), err_pc, vecs[i].exp_epc);
            chk_w($sformatf("vec%0d.err_exp", i), err_exp_value, vecs[i].exp_eexp);
            chk_w($sformatf("vec%0d.err_got", i), err_got_value, vecs[i].exp_egot);
            $display("vec%0d: dut pc=%08h golden pc=%08h -> pass=%0b cause=%0d", i, vecs[i].d_pc, vecs[i].g_pc, pass, fail_cause);
        end

        // ---- watchdog timeout; a start inside RUN must be ignored ----
        do_start();
        chk_b("wdog.busy", busy, 1'b1);
        chk_w("wdog.cause_clr", {30'd0, fail_cause}, 32'd0);
        chk_w("wdog.err_pc_clr", err_pc, 32'd0);
        chk_w("wdog.err_exp_clr", err_exp_value, 32'd0);
        chk_w("wdog.err_got_clr", err_got_value, 32'd0);
        for (int t = 1; t <= 16; t++) begin
            start = (t == 5);
            tick();
            start = 1'b0;
            if (t == 15) begin
                chk_b("wdog.fail_early", fail, 1'b0);
                chk_b("wdog.busy_15", busy, 1'b1);
            end
            if (t == 16) begin
                chk_b("wdog.fail", fail, 1'b1);
                chk_w("wdog.cause", {30'd0, fail_cause}, 32'd3);
                chk_w("wdog.err_pc", err_pc, 32'd0);
            end
        end
        $display("wdog: timeout after 16 idle cycles, cause=%0d", fail_cause);

        // ---- overflow: five commits with no golden data ----
        do_start();
        chk_b("ovf.busy_restart", busy, 1'b1);
        chk_w("ovf.cause_clr", {30'd0, fail_cause}, 32'd0);
        chk_w("ovf.err_pc_clr", err_pc, 32'd0);
        for (int k = 0; k < 5; k++) begin
            set_wb(32'h100 + 32'(k * 4), 1'b1, 5'(k + 1), 32'(k));
            tick();
            if (k == 3) begin
                chk_b("ovf.fail_at_full", fail, 1'b0);
                chk_b("ovf.ready_at_full", g_ready, 1'b1);
            end
        end
        clear_inputs();
        chk_b("ovf.fail", fail, 1'b1);
        chk_w("ovf.cause", {30'd0, fail_cause}, 32'd2);
        chk_w("ovf.err_pc", err_pc, 32'h110);
        // Sticky: nothing further may disturb the captured failure
        for (int k = 0; k < 3; k++) begin
            set_wb(32'h200, 1'b1, 5'd9, 32'h1);
            set_g(32'h300, 1'b1, 5'd9, 32'h2, 1'b0);
            tick();
        end
        clear_inputs();
        chk_b("ovf.sticky_fail", fail, 1'b1);
        chk_w("ovf.sticky_cause", {30'd0, fail_cause}, 32'd2);
        chk_w("ovf.sticky_err_pc", err_pc, 32'h110);
        $display("ovf: overflow on fifth commit, err_pc=%08h", err_pc);

        // ---- push and pop together while full: legal ----
        do_start();
        for (int k = 0; k < 4; k++) begin
            set_wb(32'h300 + 32'(k * 4), 1'b1, 5'(k + 1), 32'(k * 11));
            tick();
        end
        set_wb(32'h310, 1'b1, 5'd5, 32'd44);
        set_g(32'h300, 1'b1, 5'd1, 32'd0, 1'b0);
        tick();
        wb_have_inst = 1'b0;
        chk_b("full_pp.fail", fail, 1'b0);
        chk_b("full_pp.busy", busy, 1'b1);
        chk_w("full_pp.cnt", commit_cnt, 32'd1);
        for (int k = 1; k < 5; k++) begin
            set_g(32'h300 + 32'(k * 4), 1'b1, 5'(k + 1), 32'(k * 11), (k == 4));
            tick();
        end
        clear_inputs();
        chk_b("full_pp.pass", pass, 1'b1);
        chk_w("full_pp.cnt_end", commit_cnt, 32'd5);
        chk_w("full_pp.cause", {30'd0, fail_cause}, 32'd0);
        $display("full_pp: simultaneous push/pop at full, cnt=%0d", commit_cnt);

        // ---- asynchronous reset mid-run with two buffered entries ----
        do_start();
        set_wb(32'h400, 1'b1, 5'd1, 32'h1);
        tick();
        set_wb(32'h404, 1'b1, 5'd2, 32'h2);
        tick();
        wb_have_inst = 1'b0;
        chk_b("rst_mid.ready_before", g_ready, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("rst_mid");
        @(posedge clk);
        #3;
        rst = 1'b0;
        set_g(32'h400, 1'b1, 5'd1, 32'h1, 1'b1);
        tick();
        chk_b("rst_mid.ready_after", g_ready, 1'b0);
        chk_b("rst_mid.busy_after", busy, 1'b0);
        g_valid = 1'b0;
        do_start();
        chk_b("rst_mid.busy_restart", busy, 1'b1);
        chk_b("rst_mid.ready_restart", g_ready, 1'b0);
        clear_inputs();
        $display("rst_mid: buffered entries discarded by reset");

        // ---- randomized run against the model ----
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
        episode  = 0;
        p_commit = 50;
        p_gvalid = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!m_run) start = ($urandom_range(0, 3) == 0);
            else        start = ($urandom_range(0, 40) == 0);
            if (start && !m_run) begin
                episode++;
                case ($urandom_range(0, 2))
                    0:       p_commit = 10;
                    1:       p_commit = 50;
                    default: p_commit = 90;
                endcase
                p_gvalid = 30 + 20 * $urandom_range(0, 3);
            end
            d.pc    = $urandom & 32'hFFFF_FFFC;
            d.ena   = ($urandom_range(0, 1) == 1);
            d.rg    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            d.value = $urandom;
            gn      = make_gold(d);
            wb_have_inst = ($urandom_range(0, 99) < p_commit);
            wb_pc = d.pc; wb_ena = d.ena; wb_reg = d.rg; wb_value = d.value;
            if (mq.size() != 0) begin
                gc = mq[0].g;
                g_valid = ($urandom_range(0, 99) < p_gvalid);
            end else begin
                gc.pc = $urandom; gc.ena = 1'b1; gc.rg = 5'd1; gc.value = $urandom;
                g_valid = ($urandom_range(0, 1) == 1);
            end
            g_pc = gc.pc; g_ena = gc.ena; g_reg = gc.rg; g_value = gc.value;
            g_last = ($urandom_range(0, 11) == 0);
            chk_b("rand.g_ready", g_ready, m_run && (mq.size() != 0));
            model_edge(d, gn, gc);
            tick();
            chk_w("rand.flags", {27'd0, busy, pass, fail, fail_cause}, {27'd0, m_run, m_pass, m_fail, m_cause});
            chk_w("rand.cnt", commit_cnt, m_cnt);
            chk_w("rand.err_pc", err_pc, m_epc);
            chk_w("rand.err_exp", err_exp_value, m_eexp);
            chk_w("rand.err_got", err_got_value, m_egot);
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
